// File: rtl/mem_bus_arbiter.sv
// Two-master AXI-lite arbiter (m0 = ifetch, m1 = LSU) onto one memory slave, one transaction
// at a time. Define MEM_ARB_STARVE_GUARD_EN to bound how long m0 can be starved by m1.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  // m0: instruction fetch
  input  logic [ADDR_W-1:0]   m0_ar_addr_i,
  input  logic                m0_ar_valid_i,
  output logic                m0_ar_ready_o,
  output logic [DATA_W-1:0]   m0_r_data_o,
  output logic                m0_r_valid_o,
  input  logic                m0_r_ready_i,
  input  logic [ADDR_W-1:0]   m0_aw_addr_i,
  input  logic                m0_aw_valid_i,
  output logic                m0_aw_ready_o,
  input  logic [DATA_W-1:0]   m0_w_data_i,
  input  logic [DATA_W/8-1:0] m0_w_strb_i,
  input  logic                m0_w_valid_i,
  output logic                m0_w_ready_o,
  output logic                m0_b_valid_o,
  input  logic                m0_b_ready_i,
  // m1: load/store unit
  input  logic [ADDR_W-1:0]   m1_ar_addr_i,
  input  logic                m1_ar_valid_i,
  output logic                m1_ar_ready_o,
  output logic [DATA_W-1:0]   m1_r_data_o,
  output logic                m1_r_valid_o,
  input  logic                m1_r_ready_i,
  input  logic [ADDR_W-1:0]   m1_aw_addr_i,
  input  logic                m1_aw_valid_i,
  output logic                m1_aw_ready_o,
  input  logic [DATA_W-1:0]   m1_w_data_i,
  input  logic [DATA_W/8-1:0] m1_w_strb_i,
  input  logic                m1_w_valid_i,
  output logic                m1_w_ready_o,
  output logic                m1_b_valid_o,
  input  logic                m1_b_ready_i,
  // slave side
  output logic [ADDR_W-1:0]   s_ar_addr_o,
  output logic                s_ar_valid_o,
  input  logic                s_ar_ready_i,
  input  logic [DATA_W-1:0]   s_r_data_i,
  input  logic                s_r_valid_i,
  output logic                s_r_ready_o,
  output logic [ADDR_W-1:0]   s_aw_addr_o,
  output logic                s_aw_valid_o,
  input  logic                s_aw_ready_i,
  output logic [DATA_W-1:0]   s_w_data_o,
  output logic [DATA_W/8-1:0] s_w_strb_o,
  output logic                s_w_valid_o,
  input  logic                s_w_ready_i,
  input  logic                s_b_valid_i,
  output logic                s_b_ready_o,
  output logic                gnt_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   ar_done_q, ar_done_d, aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic rd_st, wr_st, m0_req, m1_req, force_m0, pick_m1;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic g_ar_valid, g_aw_valid, g_w_valid, g_r_ready, g_b_ready;
  logic ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;

  assign rd_st  = (state_q == StRd);
  assign wr_st  = (state_q == StWr);
  assign m0_req = m0_aw_valid_i | m0_ar_valid_i;
  assign m1_req = m1_aw_valid_i | m1_ar_valid_i;

  assign g_ar_valid = gnt_q ? m1_ar_valid_i : m0_ar_valid_i;
  assign g_aw_valid = gnt_q ? m1_aw_valid_i : m0_aw_valid_i;
  assign g_w_valid  = gnt_q ? m1_w_valid_i  : m0_w_valid_i;
  assign g_r_ready  = gnt_q ? m1_r_ready_i  : m0_r_ready_i;
  assign g_b_ready  = gnt_q ? m1_b_ready_i  : m0_b_ready_i;

  assign s_ar_addr_o  = gnt_q ? m1_ar_addr_i : m0_ar_addr_i;
  assign s_aw_addr_o  = gnt_q ? m1_aw_addr_i : m0_aw_addr_i;
  assign s_w_data_o   = gnt_q ? m1_w_data_i  : m0_w_data_i;
  assign s_w_strb_o   = gnt_q ? m1_w_strb_i  : m0_w_strb_i;
  assign s_ar_valid_o = rd_st & g_ar_valid & ~ar_done_q;
  assign s_aw_valid_o = wr_st & g_aw_valid & ~aw_done_q;
  assign s_w_valid_o  = wr_st & g_w_valid & ~w_done_q;
  assign s_r_ready_o  = rd_st & g_r_ready;
  assign s_b_ready_o  = wr_st & g_b_ready;

  // Each address/data channel is forwarded exactly once per transaction.
  assign ar_rdy = rd_st & s_ar_ready_i & ~ar_done_q;
  assign aw_rdy = wr_st & s_aw_ready_i & ~aw_done_q;
  assign w_rdy  = wr_st & s_w_ready_i & ~w_done_q;
  assign r_vld  = rd_st & s_r_valid_i;
  assign b_vld  = wr_st & s_b_valid_i;

  assign m0_ar_ready_o = ar_rdy & ~gnt_q;
  assign m1_ar_ready_o = ar_rdy & gnt_q;
  assign m0_aw_ready_o = aw_rdy & ~gnt_q;
  assign m1_aw_ready_o = aw_rdy & gnt_q;
  assign m0_w_ready_o  = w_rdy & ~gnt_q;
  assign m1_w_ready_o  = w_rdy & gnt_q;
  assign m0_r_valid_o  = r_vld & ~gnt_q;
  assign m1_r_valid_o  = r_vld & gnt_q;
  assign m0_b_valid_o  = b_vld & ~gnt_q;
  assign m1_b_valid_o  = b_vld & gnt_q;
  assign m0_r_data_o   = s_r_data_i;
  assign m1_r_data_o   = s_r_data_i;

  assign ar_hs = s_ar_valid_o & s_ar_ready_i;
  assign aw_hs = s_aw_valid_o & s_aw_ready_i;
  assign w_hs  = s_w_valid_o & s_w_ready_i;
  assign r_hs  = r_vld & g_r_ready;
  assign b_hs  = b_vld & g_b_ready;

  assign gnt_o  = gnt_q;
  assign busy_o = (state_q != StIdle);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  logic [CntW-1:0] starve_q, starve_d;

  assign force_m0 = m0_req & (starve_q == CntW'(STARVE_LIMIT));

  // Counts m1 wins over a waiting m0; any idle cycle without that condition clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle) begin
      if (!m0_req || !pick_m1) begin
        starve_d = '0;
      end else if (starve_q != CntW'(STARVE_LIMIT)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_m0 = 1'b0;
`endif

  assign pick_m1 = m1_req & ~force_m0;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req | m1_req) begin
          gnt_d   = pick_m1;
          state_d = (pick_m1 ? m1_aw_valid_i : m0_aw_valid_i) ? StWr : StRd;
        end
      end
      StRd: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          state_d   = StIdle;
          ar_done_d = 1'b0;
        end
      end
      StWr: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // An early B is a slave error but is still delivered and ends the write.
        if (b_hs) begin
          state_d   = StIdle;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q  <= starve_d;
`endif
    end
  end

endmodule
